// File: rtl/console_pkg.sv
// Shared encodings for the console command sequencer: packet types, control
// RAM addresses, one-hot state constants and the command selector.
package console_pkg;

    localparam logic [3:0] BAG_INIT   = 4'h0;
    localparam logic [3:0] BAG_DBURST = 4'h4;
    localparam logic [3:0] BAG_DIDX   = 4'h5;
    localparam logic [3:0] BAG_DPARAM = 4'h6;
    localparam logic [3:0] BAG_DDIDX  = 4'h7;
    localparam logic [3:0] BAG_DLINK  = 4'h8;
    localparam logic [3:0] BAG_DTYPE  = 4'h9;
    localparam logic [3:0] BAG_DTEMP  = 4'hA;
    localparam logic [3:0] BAG_DATA0  = 4'hD;
    localparam logic [3:0] BAG_DATA1  = 4'hE;

    localparam logic [11:0] RAM_ADDR_DLINK = 12'hFCC;
    localparam logic [11:0] RAM_ADDR_DTYPE = 12'hFC0;
    localparam logic [11:0] RAM_ADDR_DTEMP = 12'hFC4;
    localparam logic [11:0] RAM_ADDR_IDLE  = 12'hFE0;

    localparam logic [10:0] S_MAIN_IDLE = 11'b000_0000_0001;
    localparam logic [10:0] S_LINK_WORK = 11'b000_0000_0010;
    localparam logic [10:0] S_LINK_TAKE = 11'b000_0000_0100;
    localparam logic [10:0] S_LINK_SEND = 11'b000_0000_1000;
    localparam logic [10:0] S_MAIN_WAIT = 11'b000_0001_0000;
    localparam logic [10:0] S_MAIN_TAKE = 11'b000_0010_0000;
    localparam logic [10:0] S_CMD_IDLE  = 11'b000_0100_0000;
    localparam logic [10:0] S_CMD_WORK  = 11'b000_1000_0000;
    localparam logic [10:0] S_CMD_TAKE  = 11'b001_0000_0000;
    localparam logic [10:0] S_CMD_SEND  = 11'b010_0000_0000;
    localparam logic [10:0] S_CMD_DONE  = 11'b100_0000_0000;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_TYPE = 2'd1,
        CMD_CONF = 2'd2,
        CMD_CONV = 2'd3
    } cmd_e;

endpackage

// File: rtl/console_if.sv
// ADC / com-layer handshakes and packer window between the sequencer (master)
// and its environment (slave).
interface console_if #(
    parameter int ADDR_W = 12,
    parameter int DLEN_W = 12
);
    logic              fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_tran;
    logic              fd_adc_init, fd_adc_type, fd_adc_conf, fd_adc_conv, fd_adc_tran;
    logic              fs_com_send, fd_com_send;
    logic              fs_com_read, fd_com_read;
    logic [3:0]        read_btype, send_btype;
    logic [ADDR_W-1:0] ram_addr_init;
    logic [DLEN_W-1:0] ram_dlen;
    logic              busy, err_btype, err_timeout;

    modport master (
        output fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_tran,
        input  fd_adc_init, fd_adc_type, fd_adc_conf, fd_adc_conv, fd_adc_tran,
        output fs_com_send, input fd_com_send,
        input  fs_com_read, output fd_com_read,
        input  read_btype, output send_btype, ram_addr_init, ram_dlen,
        output busy, err_btype, err_timeout
    );

    modport slave (
        input  fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_tran,
        output fd_adc_init, fd_adc_type, fd_adc_conf, fd_adc_conv, fd_adc_tran,
        input  fs_com_send, output fd_com_send,
        output fs_com_read, input fd_com_read,
        output read_btype, input send_btype, ram_addr_init, ram_dlen,
        input  busy, err_btype, err_timeout
    );
endinterface

// File: rtl/console_tmo.sv
// Loadable wait-state timeout counter; expired is high in the TO_CYC-th
// enabled cycle after the last load.
module console_tmo #(
    parameter int TO_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)    cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == CW'(TO_CYC - 1));
endmodule

// File: rtl/console_seq.sv
// Console command sequencer: ADC power-up and link report, then one host
// command at a time. Optional wait timeout under CONSOLE_TIMEOUT_EN.
module console_seq
    import console_pkg::*;
#(
    parameter int CHN_NUM     = 6,
    parameter int ADDR_W      = 12,
    parameter int DLEN_W      = 12,
    parameter int DATA_BASE   = 'h000,
    parameter int DATA_STRIDE = 'h240,
    parameter int DATA_DLEN   = 'h202,
    parameter int CTRL_DLEN   = 'h002,
    parameter int TO_CYC      = 65535
) (
    input logic       clk,
    input logic       rst,
    console_if.master bus
);
    logic [10:0]       state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [3:0]        num_q, num_d, rem_q, rem_d;
    logic              send_ok_q, send_ok_d, tran_ok_q, tran_ok_d;
    logic [3:0]        btype_q, btype_d;
    logic [ADDR_W-1:0] addr_q, addr_d, slot_addr;
    logic [DLEN_W-1:0] dlen_q, dlen_d;
    logic              busy_q, busy_d, err_bt_q, err_bt_d, err_to_q, err_to_d;
    logic              tmo, adc_done, send_hit, tran_hit;

    assign slot_addr = ADDR_W'(DATA_BASE + int'(num_q) * DATA_STRIDE);

    always_comb begin
        adc_done = (cmd_q == CMD_TYPE) ? bus.fd_adc_type :
                   (cmd_q == CMD_CONF) ? bus.fd_adc_conf : bus.fd_adc_conv;
        send_hit = send_ok_q || bus.fd_com_send;
        tran_hit = (cmd_q != CMD_CONV) || tran_ok_q || bus.fd_adc_tran;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        num_d     = num_q;
        rem_d     = rem_q;
        send_ok_d = 1'b0;
        tran_ok_d = 1'b0;
        btype_d   = btype_q;
        addr_d    = addr_q;
        dlen_d    = dlen_q;
        err_bt_d  = 1'b0;
        err_to_d  = 1'b0;
        case (state_q)
            S_MAIN_IDLE: begin
                num_d   = '0;
                state_d = S_LINK_WORK;
            end
            S_LINK_WORK: begin
                if (bus.fd_adc_init) state_d = S_LINK_TAKE;
                else if (tmo) begin
                    state_d  = S_MAIN_IDLE;
                    err_to_d = 1'b1;
                end
            end
            S_LINK_TAKE: begin
                btype_d = BAG_DLINK;
                addr_d  = ADDR_W'(RAM_ADDR_DLINK);
                dlen_d  = DLEN_W'(CTRL_DLEN);
                state_d = S_LINK_SEND;
            end
            S_LINK_SEND: begin
                if (bus.fd_com_send) state_d = S_MAIN_WAIT;
                else if (tmo) begin
                    state_d  = S_MAIN_IDLE;
                    err_to_d = 1'b1;
                end
            end
            S_MAIN_WAIT: if (bus.fs_com_read) state_d = S_MAIN_TAKE;
            S_MAIN_TAKE: begin
                rem_d   = '0;
                state_d = S_CMD_IDLE;
                case (bus.read_btype)
                    BAG_DIDX:   cmd_d = CMD_TYPE;
                    BAG_DPARAM: cmd_d = CMD_CONF;
                    BAG_DDIDX:  cmd_d = CMD_CONV;
                    BAG_DBURST: begin
                        cmd_d = CMD_CONV;
                        rem_d = 4'(CHN_NUM - 1);
                    end
                    default: begin
                        cmd_d    = CMD_NONE;
                        err_bt_d = 1'b1;
                    end
                endcase
            end
            S_CMD_IDLE: begin
                if (!bus.fs_com_read) state_d = (cmd_q == CMD_NONE) ? S_MAIN_WAIT : S_CMD_WORK;
            end
            S_CMD_WORK: begin
                if (adc_done) state_d = S_CMD_TAKE;
                else if (tmo) begin
                    state_d  = S_MAIN_WAIT;
                    err_to_d = 1'b1;
                end
            end
            S_CMD_TAKE: begin
                state_d = S_CMD_SEND;
                dlen_d  = DLEN_W'(CTRL_DLEN);
                if (cmd_q == CMD_TYPE) begin
                    btype_d = BAG_DTYPE;
                    addr_d  = ADDR_W'(RAM_ADDR_DTYPE);
                end else if (cmd_q == CMD_CONF) begin
                    btype_d = BAG_DTEMP;
                    addr_d  = ADDR_W'(RAM_ADDR_DTEMP);
                end else begin
                    btype_d = num_q[0] ? BAG_DATA1 : BAG_DATA0;
                    addr_d  = slot_addr;
                    dlen_d  = DLEN_W'(DATA_DLEN);
                    num_d   = (num_q == 4'(CHN_NUM - 1)) ? '0 : num_q + 4'd1;
                end
            end
            S_CMD_SEND: begin
                // both dones may land in different cycles; hold each until exit
                if (send_hit && tran_hit) state_d = S_CMD_DONE;
                else if (tmo) begin
                    state_d  = S_MAIN_WAIT;
                    err_to_d = 1'b1;
                end else begin
                    send_ok_d = send_hit;
                    tran_ok_d = tran_ok_q || bus.fd_adc_tran;
                end
            end
            S_CMD_DONE: begin
                if (rem_q != '0) begin
                    rem_d   = rem_q - 4'd1;
                    state_d = S_CMD_WORK;
                end else state_d = S_MAIN_WAIT;
            end
            default: state_d = S_MAIN_IDLE;
        endcase
        if (state_d == S_MAIN_WAIT || state_d == S_MAIN_IDLE) begin
            btype_d = BAG_INIT;
            addr_d  = ADDR_W'(RAM_ADDR_IDLE);
            dlen_d  = '0;
        end
        busy_d = (state_d != S_MAIN_WAIT);
    end

`ifdef CONSOLE_TIMEOUT_EN
    logic tmo_en;
    assign tmo_en = (state_q == S_LINK_WORK) || (state_q == S_LINK_SEND) ||
                    (state_q == S_CMD_WORK)  || (state_q == S_CMD_SEND);
    console_tmo #(.TO_CYC(TO_CYC)) u_tmo (
        .clk(clk), .rst(rst), .load(state_d != state_q), .en(tmo_en), .expired(tmo)
    );
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_MAIN_IDLE;
            cmd_q     <= CMD_NONE;
            num_q     <= '0;
            rem_q     <= '0;
            send_ok_q <= 1'b0;
            tran_ok_q <= 1'b0;
            btype_q   <= BAG_INIT;
            addr_q    <= ADDR_W'(RAM_ADDR_IDLE);
            dlen_q    <= '0;
            busy_q    <= 1'b0;
            err_bt_q  <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            send_ok_q <= send_ok_d;
            tran_ok_q <= tran_ok_d;
            btype_q   <= btype_d;
            addr_q    <= addr_d;
            dlen_q    <= dlen_d;
            busy_q    <= busy_d;
            err_bt_q  <= err_bt_d;
            err_to_q  <= err_to_d;
        end
    end

    assign bus.fs_adc_init   = (state_q == S_LINK_WORK);
    assign bus.fs_adc_type   = (state_q == S_CMD_WORK) && (cmd_q == CMD_TYPE);
    assign bus.fs_adc_conf   = (state_q == S_CMD_WORK) && (cmd_q == CMD_CONF);
    assign bus.fs_adc_conv   = (state_q == S_CMD_WORK) && (cmd_q == CMD_CONV);
    assign bus.fs_adc_tran   = (state_q == S_CMD_SEND) && (cmd_q == CMD_CONV);
    assign bus.fs_com_send   = (state_q == S_LINK_SEND) || (state_q == S_CMD_SEND);
    assign bus.fd_com_read   = (state_q == S_CMD_IDLE);
    assign bus.send_btype    = btype_q;
    assign bus.ram_addr_init = addr_q;
    assign bus.ram_dlen      = dlen_q;
    assign bus.busy          = busy_q;
    assign bus.err_btype     = err_bt_q;
    assign bus.err_timeout   = err_to_q;
endmodule
